// File: rtl/sprite_line_pkg.sv
// Shared types and default sizing for the per-scanline sprite matcher.
// Pure declarations: no latency or flow-control behaviour of its own.
package sprite_line_pkg;

    localparam int DEF_NUM_SPRITES  = 512;
    localparam int DEF_MAX_PER_LINE = 64;
    localparam int DEF_Y_W          = 11;
    localparam int DEF_H_W          = 4;
    localparam int DEF_ROW_SHIFT    = 4;
    localparam int DEF_IDX_W        = $clog2(DEF_NUM_SPRITES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } scan_state_t;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] sprite;
        logic [DEF_Y_W-1:0]   row;
    } active_entry_t;

endpackage

// File: rtl/sprite_line_matcher_pingpong.sv
// Two-bank active list: one write port into bank wr_bank, one read port on the other bank.
// Read data registered (1 cycle); no backpressure, writes always accepted.
module active_list_pingpong #(
    parameter int DEPTH = 64,
    parameter int DW    = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_draw,
    input  logic          rst_draw_n,
    input  logic          wr_bank,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    // List storage is deliberately left unreset; rd_count gates what is meaningful.
    always_ff @(posedge clk_draw) begin
        if (wr_en) begin
            if (wr_bank) begin
                mem1[wr_addr] <= wr_data;
            end else begin
                mem0[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= wr_bank ? mem0[rd_addr] : mem1[rd_addr];
        end
    end

endmodule

// File: rtl/sprite_line_matcher.sv
// Per-scanline sprite Y matcher: scans the sprite table, builds a ping-pong active list.
// Scan takes NUM_SPRITES+1 cycles after line; read port 1-cycle latency; no backpressure.
module sprite_line_matcher
    import sprite_line_pkg::*;
#(
    parameter int NUM_SPRITES  = DEF_NUM_SPRITES,
    parameter int MAX_PER_LINE = DEF_MAX_PER_LINE,
    parameter int Y_W          = DEF_Y_W,
    parameter int H_W          = DEF_H_W,
    parameter int ROW_SHIFT    = DEF_ROW_SHIFT,
    parameter int IDX_W        = $clog2(NUM_SPRITES),
    parameter int CNT_W        = $clog2(MAX_PER_LINE) + 1
) (
    input  logic             clk_draw,
    input  logic             rst_draw_n,
    input  logic             enable,
    input  logic             line,
    input  logic [Y_W-1:0]   sy,
    output logic             tbl_rd_en,
    output logic [IDX_W-1:0] tbl_addr,
    input  logic [Y_W-1:0]   tbl_y,
    input  logic [H_W-1:0]   tbl_height,
    input  logic             tbl_y_flip,
    input  logic [CNT_W-2:0] rd_index,
    output logic [IDX_W-1:0] rd_sprite,
    output logic [Y_W-1:0]   rd_row,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_count,
    output logic             overflow,
    output logic             incomplete,
    output logic             busy
);

    localparam int SPAN_W = H_W + ROW_SHIFT;
    localparam int CW     = (Y_W + 1 > SPAN_W) ? Y_W + 1 : SPAN_W;
    localparam int AW     = CNT_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(MAX_PER_LINE);

    scan_state_t      state;
    logic             bank;
    logic [CNT_W-1:0] wr_cnt;
    logic             wr_ovf;
    logic [Y_W-1:0]   sy_l;
    logic             rsp_vld;
    logic [IDX_W-1:0] rsp_idx;

    logic [CW-1:0]    d;
    logic [CW-1:0]    span;
    logic [Y_W-1:0]   row;
    logic             hit;
    logic             room;
    logic             wr_en;

    // Widened subtraction so a sprite above the line can never wrap into a match.
    assign d     = CW'(sy_l) - CW'(tbl_y);
    assign span  = CW'(tbl_height) << ROW_SHIFT;
    assign hit   = rsp_vld && (sy_l >= tbl_y) && (d < span);
    assign row   = tbl_y_flip ? Y_W'(span - CW'(1) - d) : Y_W'(d);
    assign room  = wr_cnt < CAP;
    assign wr_en = hit && room && !line;

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state      <= ST_IDLE;
            bank       <= 1'b0;
            wr_cnt     <= '0;
            wr_ovf     <= 1'b0;
            sy_l       <= '0;
            rsp_vld    <= 1'b0;
            rsp_idx    <= '0;
            tbl_rd_en  <= 1'b0;
            tbl_addr   <= '0;
            busy       <= 1'b0;
            rd_count   <= '0;
            overflow   <= 1'b0;
            incomplete <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= CNT_W'(rd_index) < rd_count;
            if (line) begin
                // Hand the finished list to the reader; any response still in flight is dropped.
                bank       <= ~bank;
                rd_count   <= wr_cnt;
                overflow   <= wr_ovf;
                incomplete <= (state != ST_IDLE);
                wr_cnt     <= '0;
                wr_ovf     <= 1'b0;
                sy_l       <= sy;
                rsp_vld    <= 1'b0;
                tbl_addr   <= '0;
                state      <= enable ? ST_SCAN : ST_IDLE;
                tbl_rd_en  <= enable;
                busy       <= enable;
            end else begin
                rsp_vld <= tbl_rd_en;
                rsp_idx <= tbl_addr;
                if (hit) begin
                    if (room) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end else begin
                        wr_ovf <= 1'b1;
                    end
                end
                case (state)
                    ST_SCAN: begin
                        if (tbl_addr == LAST_IDX) begin
                            state     <= ST_DRAIN;
                            tbl_rd_en <= 1'b0;
                        end else begin
                            tbl_addr <= tbl_addr + IDX_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    active_list_pingpong #(
        .DEPTH (MAX_PER_LINE),
        .DW    (IDX_W + Y_W),
        .AW    (AW)
    ) u_list (
        .clk_draw   (clk_draw),
        .rst_draw_n (rst_draw_n),
        .wr_bank    (bank),
        .wr_en      (wr_en),
        .wr_addr    (wr_cnt[AW-1:0]),
        .wr_data    ({rsp_idx, row}),
        .rd_addr    (rd_index),
        .rd_data    ({rd_sprite, rd_row})
    );

endmodule

// File: tb/tb_sprite_line_matcher.sv
// Directed bench for sprite_line_matcher at default parameters with a behavioural sprite table.
module tb_sprite_line_matcher;

    logic        clk_draw = 1'b0;
    logic        rst_draw_n;
    logic        enable;
    logic        line;
    logic [10:0] sy;
    logic        tbl_rd_en;
    logic [8:0]  tbl_addr;
    logic [10:0] tbl_y;
    logic [3:0]  tbl_height;
    logic        tbl_y_flip;
    logic [5:0]  rd_index;
    logic [8:0]  rd_sprite;
    logic [10:0] rd_row;
    logic        rd_valid;
    logic [6:0]  rd_count;
    logic        overflow;
    logic        incomplete;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] ty [512];
    logic [3:0]  th [512];
    logic        tf [512];

    sprite_line_matcher u_dut (
        .clk_draw   (clk_draw),
        .rst_draw_n (rst_draw_n),
        .enable     (enable),
        .line       (line),
        .sy         (sy),
        .tbl_rd_en  (tbl_rd_en),
        .tbl_addr   (tbl_addr),
        .tbl_y      (tbl_y),
        .tbl_height (tbl_height),
        .tbl_y_flip (tbl_y_flip),
        .rd_index   (rd_index),
        .rd_sprite  (rd_sprite),
        .rd_row     (rd_row),
        .rd_valid   (rd_valid),
        .rd_count   (rd_count),
        .overflow   (overflow),
        .incomplete (incomplete),
        .busy       (busy)
    );

    always #5 clk_draw = ~clk_draw;

    // Sprite table RAM: response one cycle after the read strobe.
    always @(posedge clk_draw) begin
        if (tbl_rd_en) begin
            tbl_y      <= ty[tbl_addr];
            tbl_height <= th[tbl_addr];
            tbl_y_flip <= tf[tbl_addr];
        end
    end

    task automatic clear_table;
        for (int i = 0; i < 512; i++) begin
            ty[i] = '0;
            th[i] = '0;
            tf[i] = 1'b0;
        end
    endtask

    task automatic pulse_line(input logic en, input logic [10:0] y);
        @(negedge clk_draw);
        line   = 1'b1;
        enable = en;
        sy     = y;
        @(negedge clk_draw);
        line   = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 700) begin
            @(negedge clk_draw);
            cycles++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cycles);
        end
    endtask

    task automatic run_line(input logic [10:0] y);
        int c;
        pulse_line(1'b1, y);
        wait_idle(c);
        pulse_line(1'b0, 11'd0);
    endtask

    task automatic read_at(input logic [5:0] idx);
        rd_index = idx;
        @(negedge clk_draw);
    endtask

    task automatic test_reset;
        rst_draw_n = 1'b1;
        enable     = 1'b0;
        line       = 1'b0;
        sy         = '0;
        rd_index   = '0;
        clear_table();
        #1 rst_draw_n = 1'b0;
        #2;
        n_checks++;
        if ({tbl_rd_en, busy, rd_valid, overflow, incomplete} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000", {tbl_rd_en, busy, rd_valid, overflow, incomplete});
        end
        n_checks++;
        if (rd_count !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, required 0", rd_count);
        end
        n_checks++;
        if ({rd_sprite, rd_row} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_data: got sprite %0d row %0d, required 0 0", rd_sprite, rd_row);
        end
        repeat (2) @(negedge clk_draw);
        rst_draw_n = 1'b1;
        repeat (3) @(negedge clk_draw);
        n_checks++;
        if ({tbl_rd_en, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: rd_en/busy=%b, required 00", {tbl_rd_en, busy});
        end
    endtask

    task automatic test_basic;
        int c;
        clear_table();
        ty[5] = 11'd100;
        th[5] = 4'd2;
        pulse_line(1'b1, 11'd110);
        wait_idle(c);
        n_checks++;
        if (c != 513) begin
            n_fail++;
            $display("FAIL basic_scan_len: busy for %0d cycles, required 513", c);
        end
        pulse_line(1'b0, 11'd0);
        n_checks++;
        if ({rd_count, overflow, incomplete} !== {7'd1, 2'b00}) begin
            n_fail++;
            $display("FAIL basic_status: count=%0d ovf=%b inc=%b, required 1 0 0", rd_count, overflow, incomplete);
        end
        read_at(6'd0);
        n_checks++;
        if ({rd_valid, rd_sprite, rd_row} !== {1'b1, 9'd5, 11'd10}) begin
            n_fail++;
            $display("FAIL basic_entry0: valid=%b sprite=%0d row=%0d, required 1 5 10", rd_valid, rd_sprite, rd_row);
        end
        read_at(6'd1);
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_entry1_valid: got %b, required 0", rd_valid);
        end
    endtask

    int         b_sy    [6] = '{99, 100, 131, 132, 100, 110};
    logic       b_flip  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [6:0] b_count [6] = '{7'd0, 7'd1, 7'd1, 7'd0, 7'd1, 7'd1};
    int         b_row   [6] = '{0, 0, 31, 0, 31, 21};

    task automatic test_boundaries;
        clear_table();
        ty[5] = 11'd100;
        th[5] = 4'd2;
        for (int k = 0; k < 6; k++) begin
            tf[5] = b_flip[k];
            run_line(11'(b_sy[k]));
            read_at(6'd0);
            n_checks++;
            if (rd_count !== b_count[k]) begin
                n_fail++;
                $display("FAIL bound_count sy=%0d: got %0d, required %0d", b_sy[k], rd_count, b_count[k]);
            end
            if (b_count[k] == 7'd1) begin
                n_checks++;
                if ({rd_sprite, rd_row} !== {9'd5, 11'(b_row[k])}) begin
                    n_fail++;
                    $display("FAIL bound_row sy=%0d flip=%b: got sprite %0d row %0d, required 5 %0d",
                             b_sy[k], b_flip[k], rd_sprite, rd_row, b_row[k]);
                end
            end
        end
    endtask

    task automatic test_overflow;
        clear_table();
        for (int i = 0; i < 66; i++) begin
            ty[2*i+1] = 11'd200;
            th[2*i+1] = 4'd1;
        end
        run_line(11'd205);
        n_checks++;
        if ({rd_count, overflow, incomplete} !== {7'd64, 2'b10}) begin
            n_fail++;
            $display("FAIL ovf_status: count=%0d ovf=%b inc=%b, required 64 1 0", rd_count, overflow, incomplete);
        end
        read_at(6'd0);
        n_checks++;
        if ({rd_sprite, rd_row} !== {9'd1, 11'd5}) begin
            n_fail++;
            $display("FAIL ovf_entry0: sprite %0d row %0d, required 1 5", rd_sprite, rd_row);
        end
        read_at(6'd31);
        n_checks++;
        if (rd_sprite !== 9'd63) begin
            n_fail++;
            $display("FAIL ovf_entry31: sprite %0d, required 63", rd_sprite);
        end
        read_at(6'd63);
        n_checks++;
        if ({rd_valid, rd_sprite} !== {1'b1, 9'd127}) begin
            n_fail++;
            $display("FAIL ovf_entry63: valid=%b sprite %0d, required 1 127", rd_valid, rd_sprite);
        end
        clear_table();
        run_line(11'd205);
        n_checks++;
        if ({rd_count, overflow} !== {7'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_clear: count=%0d ovf=%b, required 0 0", rd_count, overflow);
        end
    endtask

    int inc_idx [7] = '{0, 2, 4, 6, 8, 9, 10};

    task automatic test_incomplete;
        int c;
        clear_table();
        foreach (inc_idx[k]) begin
            ty[inc_idx[k]] = 11'd50;
            th[inc_idx[k]] = 4'd1;
        end
        pulse_line(1'b1, 11'd60);
        repeat (9) @(negedge clk_draw);
        pulse_line(1'b1, 11'd60);
        n_checks++;
        if ({rd_count, incomplete} !== {7'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL inc_status: count=%0d inc=%b, required 5 1", rd_count, incomplete);
        end
        n_checks++;
        if ({tbl_rd_en, tbl_addr} !== {1'b1, 9'd0}) begin
            n_fail++;
            $display("FAIL inc_restart: rd_en=%b addr=%0d, required 1 0", tbl_rd_en, tbl_addr);
        end
        read_at(6'd4);
        n_checks++;
        if ({rd_sprite, rd_row} !== {9'd8, 11'd10}) begin
            n_fail++;
            $display("FAIL inc_entry4: sprite %0d row %0d, required 8 10", rd_sprite, rd_row);
        end
        wait_idle(c);
        pulse_line(1'b0, 11'd0);
        n_checks++;
        if ({rd_count, incomplete} !== {7'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL inc_full_rescan: count=%0d inc=%b, required 7 0", rd_count, incomplete);
        end
    endtask

    task automatic test_disable;
        clear_table();
        ty[5] = 11'd100;
        th[5] = 4'd2;
        pulse_line(1'b0, 11'd110);
        repeat (3) @(negedge clk_draw);
        n_checks++;
        if ({tbl_rd_en, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL dis_idle: rd_en/busy=%b, required 00", {tbl_rd_en, busy});
        end
        pulse_line(1'b0, 11'd110);
        n_checks++;
        if ({rd_count, incomplete} !== {7'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL dis_list: count=%0d inc=%b, required 0 0", rd_count, incomplete);
        end
    endtask

    task automatic test_async_reset;
        logic seen;
        run_line(11'd110);
        read_at(6'd0);
        n_checks++;
        if ({rd_count, rd_valid} !== {7'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL arst_pre: count=%0d valid=%b, required 1 1", rd_count, rd_valid);
        end
        pulse_line(1'b1, 11'd110);
        repeat (5) @(negedge clk_draw);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_midscan_busy: got %b, required 1", busy);
        end
        #2 rst_draw_n = 1'b0;
        #1;
        n_checks++;
        if ({tbl_rd_en, busy, rd_valid, overflow, incomplete, rd_count, rd_sprite, rd_row, tbl_addr} !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs: en=%b busy=%b valid=%b ovf=%b inc=%b count=%0d sprite=%0d row=%0d addr=%0d, required all 0",
                     tbl_rd_en, busy, rd_valid, overflow, incomplete, rd_count, rd_sprite, rd_row, tbl_addr);
        end
        @(negedge clk_draw);
        rst_draw_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk_draw);
            seen = seen | tbl_rd_en | busy;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_stay_idle: rd_en or busy seen=%b, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_overflow();
        test_incomplete();
        test_disable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
